// File: rtl/preamble_burst_controller.sv
`timescale 1ns/1ps
// Gates one burst of samples per long-preamble marker once a short-preamble sync has armed the search.
// The burst data path is a zero-latency AXI-stream pass-through; counters report bursts and sync timeouts.
module preamble_burst_controller #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 256,
  parameter int HOLDOFF = 64,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             clear_counts,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tsync,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_burst_count,
  output logic [CNT_W-1:0] o_timeout_count
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_BURST, S_HOLDOFF} state_e;

  // Where a finished burst goes: straight back to IDLE when no holdoff is configured.
  localparam state_e S_DONE = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [HLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;

  logic             beat;
  logic             burst_done;
  logic             timed_out;
  logic [LEN_W-1:0] len_eff;

  assign len_eff    = (burst_len == '0) ? LEN_W'(1) : burst_len;
  assign beat       = i_tvalid & i_tready;
  assign burst_done = beat & o_tlast;

  // NOTE: non-blocking assignments for every flop so all registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      remaining_q   <= '0;
      hold_q        <= '0;
      burst_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      remaining_q   <= remaining_d;
      hold_q        <= hold_d;
      burst_cnt_q   <= burst_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  // NOTE: every variable gets a default at the top so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    hold_d      = hold_q;
    timed_out   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (beat && i_tsync && enable) begin
          state_d = S_ARMED;
          timer_d = '0;
        end
      end
      S_ARMED: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (beat) begin
          if (i_tlast) begin
            remaining_d = len_eff - LEN_W'(1);
            hold_d      = '0;
            state_d     = (len_eff == LEN_W'(1)) ? S_DONE : S_BURST;
          end else if (i_tsync) begin
            timer_d = '0;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            timed_out = 1'b1;
            state_d   = S_IDLE;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      S_BURST: begin
        // enable is deliberately ignored here so a started burst always completes.
        if (beat) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            hold_d  = '0;
            state_d = S_DONE;
          end
        end
      end
      S_HOLDOFF: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (beat) begin
          if (hold_q == HLD_W'(HOLDOFF - 1)) state_d = S_IDLE;
          else                               hold_d  = hold_q + HLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_comb begin
    burst_cnt_d   = burst_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    if (burst_done && !(&burst_cnt_q))  burst_cnt_d   = burst_cnt_q + CNT_W'(1);
    if (timed_out && !(&timeout_cnt_q)) timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
    if (clear_counts) begin
      burst_cnt_d   = '0;
      timeout_cnt_d = '0;
    end
  end

  // Outside the marker beat and the burst, input is drained unconditionally and nothing is presented.
  always_comb begin
    i_tready = 1'b1;
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    unique case (state_q)
      S_ARMED: begin
        if (enable && i_tlast) begin
          i_tready = o_tready;
          o_tvalid = i_tvalid;
          o_tlast  = (len_eff == LEN_W'(1));
        end
      end
      S_BURST: begin
        i_tready = o_tready;
        o_tvalid = i_tvalid;
        o_tlast  = (remaining_q == LEN_W'(1));
      end
      default: ;
    endcase
  end

  assign o_tdata         = i_tdata;
  assign o_busy          = (state_q != S_IDLE);
  assign o_burst_count   = burst_cnt_q;
  assign o_timeout_count = timeout_cnt_q;

endmodule

// File: tb/tb_preamble_burst_controller.sv
`timescale 1ns/1ps
// Bench for preamble_burst_controller: vector table, directed multi-cycle sequences, and a random
// stream scored against a beat-level reference model; a narrow-counter instance covers saturation.
module tb_preamble_burst_controller;

  localparam int WIDTH   = 32;
  localparam int LEN_W   = 16;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 256;
  localparam int HOLDOFF = 64;
  localparam int S_CNT_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1, enable = 1'b0, clear_counts = 1'b0;
  logic             i_tsync = 1'b0, i_tlast = 1'b0, i_tvalid = 1'b0, o_tready = 1'b1;
  logic [LEN_W-1:0] burst_len = '0;
  logic [WIDTH-1:0] i_tdata = '0;

  logic             i_tready, o_tlast, o_tvalid, o_busy;
  logic [WIDTH-1:0] o_tdata;
  logic [CNT_W-1:0] o_burst_count, o_timeout_count;

  logic               s_i_tready, s_o_tlast, s_o_tvalid, s_o_busy;
  logic [WIDTH-1:0]   s_o_tdata;
  logic [S_CNT_W-1:0] s_burst_count, s_timeout_count;

  preamble_burst_controller #(
    .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .burst_len(burst_len), .clear_counts(clear_counts),
    .i_tdata(i_tdata), .i_tsync(i_tsync), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready), .o_busy(o_busy),
    .o_burst_count(o_burst_count), .o_timeout_count(o_timeout_count)
  );

  preamble_burst_controller #(
    .WIDTH(WIDTH), .TIMEOUT(2), .HOLDOFF(0), .LEN_W(LEN_W), .CNT_W(S_CNT_W)
  ) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .burst_len(burst_len), .clear_counts(clear_counts),
    .i_tdata(i_tdata), .i_tsync(i_tsync), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(s_i_tready),
    .o_tdata(s_o_tdata), .o_tlast(s_o_tlast), .o_tvalid(s_o_tvalid), .o_tready(o_tready), .o_busy(s_o_busy),
    .o_burst_count(s_burst_count), .o_timeout_count(s_timeout_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the following falling edge.
  task automatic drive(input logic rst, input logic en, input logic vld, input logic sync,
                       input logic last, input logic rdy, input logic [LEN_W-1:0] bl,
                       input logic [WIDTH-1:0] d, input logic clr);
    @(posedge clk);
    #1;
    reset = rst; enable = en; i_tvalid = vld; i_tsync = sync; i_tlast = last;
    o_tready = rdy; burst_len = bl; i_tdata = d; clear_counts = clr;
    @(negedge clk);
  endtask

  task automatic beat(input logic sync, input logic last, input logic [LEN_W-1:0] bl,
                      input logic [WIDTH-1:0] d);
    drive(1'b0, 1'b1, 1'b1, sync, last, 1'b1, bl, d, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
  endtask

  typedef struct {
    logic rst, en, vld, sync, last, rdy;
    logic [LEN_W-1:0] bl;
    logic [WIDTH-1:0] d;
    logic e_irdy, e_ovld, e_olast, e_busy;
    logic [CNT_W-1:0] e_bc, e_tc;
  } vec_t;

  typedef struct {
    logic sync, last;
    logic [LEN_W-1:0] bl;
    logic [WIDTH-1:0] d;
  } item_t;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic l;
  } out_t;

  vec_t  vecs[$];
  item_t items[$];
  out_t  exp_q[$];
  out_t  got_q[$];
  int    exp_bc, exp_tc;

  // Reference model: walks the accepted-beat sequence and lists every sample that must leave, with its last flag.
  task automatic run_model();
    int phase = 0;
    int tmr = 0, left = 0, hold = 0, len = 0;
    exp_q.delete();
    exp_bc = 0;
    exp_tc = 0;
    foreach (items[i]) begin
      case (phase)
        0: if (items[i].sync) begin phase = 1; tmr = 0; end
        1: begin
          if (items[i].last) begin
            len = (items[i].bl == 0) ? 1 : int'(items[i].bl);
            exp_q.push_back(out_t'{items[i].d, (len == 1)});
            if (len == 1) begin exp_bc++; phase = 3; hold = 0; end
            else begin left = len - 1; phase = 2; end
          end else if (items[i].sync) begin
            tmr = 0;
          end else begin
            tmr++;
            if (tmr == TIMEOUT) begin exp_tc++; phase = 0; end
          end
        end
        2: begin
          left--;
          exp_q.push_back(out_t'{items[i].d, (left == 0)});
          if (left == 0) begin exp_bc++; phase = 3; hold = 0; end
        end
        default: begin
          hold++;
          if (hold == HOLDOFF) phase = 0;
        end
      endcase
    end
  endtask

  initial begin
    logic [WIDTH-1:0] bp_data[3];
    logic [WIDTH-1:0] bp_got_d[3];
    logic             bp_got_l[3];
    int               idx, got, cyc;
    item_t            it;
    logic             vld, rdy;

    do_reset();

    // Cycle-by-cycle vectors: reset state, ignored marker, stall on the marker, len=2 and len=0 bursts, enable drop.
    vecs.push_back(vec_t'{1,0,0,0,0,1, 16'd0, 32'h0,    1,0,0,0, 16'd0, 16'd0});
    vecs.push_back(vec_t'{0,1,1,0,1,1, 16'd3, 32'hA1,   1,0,0,0, 16'd0, 16'd0});
    vecs.push_back(vec_t'{0,1,1,1,0,1, 16'd3, 32'hA2,   1,0,0,0, 16'd0, 16'd0});
    vecs.push_back(vec_t'{0,1,1,0,0,1, 16'd3, 32'hA3,   1,0,0,1, 16'd0, 16'd0});
    vecs.push_back(vec_t'{0,1,1,0,1,0, 16'd2, 32'hA4,   0,1,0,1, 16'd0, 16'd0});
    vecs.push_back(vec_t'{0,1,1,0,1,1, 16'd2, 32'hA4,   1,1,0,1, 16'd0, 16'd0});
    vecs.push_back(vec_t'{0,1,1,1,1,1, 16'd9, 32'hA5,   1,1,1,1, 16'd0, 16'd0});
    vecs.push_back(vec_t'{0,1,1,0,0,1, 16'd0, 32'hA6,   1,0,0,1, 16'd1, 16'd0});
    vecs.push_back(vec_t'{0,0,0,0,0,1, 16'd0, 32'h0,    1,0,0,1, 16'd1, 16'd0});
    vecs.push_back(vec_t'{0,1,1,0,0,1, 16'd0, 32'hA7,   1,0,0,0, 16'd1, 16'd0});
    vecs.push_back(vec_t'{0,1,1,1,0,1, 16'd0, 32'hA8,   1,0,0,0, 16'd1, 16'd0});
    vecs.push_back(vec_t'{0,1,1,0,1,1, 16'd0, 32'hA9,   1,1,1,1, 16'd1, 16'd0});
    vecs.push_back(vec_t'{0,1,0,0,0,1, 16'd0, 32'h0,    1,0,0,1, 16'd2, 16'd0});
    vecs.push_back(vec_t'{0,0,0,0,0,1, 16'd0, 32'h0,    1,0,0,1, 16'd2, 16'd0});
    vecs.push_back(vec_t'{0,1,1,1,0,1, 16'd0, 32'hB1,   1,0,0,0, 16'd2, 16'd0});
    vecs.push_back(vec_t'{0,0,1,0,0,1, 16'd1, 32'hB2,   1,0,0,1, 16'd2, 16'd0});
    vecs.push_back(vec_t'{0,1,1,0,1,1, 16'd1, 32'hB3,   1,0,0,0, 16'd2, 16'd0});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].sync, vecs[i].last, vecs[i].rdy,
            vecs[i].bl, vecs[i].d, 1'b0);
      check($sformatf("vec%0d.i_tready", i), i_tready, vecs[i].e_irdy);
      check($sformatf("vec%0d.o_tvalid", i), o_tvalid, vecs[i].e_ovld);
      check($sformatf("vec%0d.o_tlast", i), o_tlast & o_tvalid, vecs[i].e_olast);
      check($sformatf("vec%0d.o_busy", i), o_busy, vecs[i].e_busy);
      check($sformatf("vec%0d.burst_count", i), o_burst_count, vecs[i].e_bc);
      check($sformatf("vec%0d.timeout_count", i), o_timeout_count, vecs[i].e_tc);
      if (vecs[i].e_ovld) check($sformatf("vec%0d.o_tdata", i), o_tdata, vecs[i].d);
    end

    // Sync, marker 10 beats later, 5-sample burst, then 64 dropped beats before IDLE.
    do_reset();
    beat(1'b1, 1'b0, 16'd5, 32'h1);
    for (int k = 1; k < 10; k++) beat(1'b0, 1'b0, 16'd5, 32'h100 + k);
    for (int k = 0; k < 5; k++) begin
      beat(1'b0, (k == 0), 16'd5, 32'hC000 + k);
      check($sformatf("s1.o_tvalid%0d", k), o_tvalid, 1'b1);
      check($sformatf("s1.o_tlast%0d", k), o_tlast, (k == 4));
      check($sformatf("s1.o_tdata%0d", k), o_tdata, 32'hC000 + k);
    end
    for (int h = 0; h < HOLDOFF; h++) begin
      beat(1'b1, 1'b1, 16'd5, 32'hD000 + h);
      if (h == 0 || h == HOLDOFF - 1) begin
        check($sformatf("s1.hold_busy%0d", h), o_busy, 1'b1);
        check($sformatf("s1.hold_ovld%0d", h), o_tvalid, 1'b0);
      end
    end
    idle();
    check("s1.idle_busy", o_busy, 1'b0);
    check("s1.burst_count", o_burst_count, 16'd1);

    // Timeout after 256 unmarked beats, then a marker exactly on beat 256 wins.
    do_reset();
    beat(1'b1, 1'b0, 16'd2, 32'h0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      beat(1'b0, 1'b0, 16'd2, 32'h200 + k);
      if (k == TIMEOUT) check("s2.busy_on_256", o_busy, 1'b1);
    end
    idle();
    check("s2.timeout_busy", o_busy, 1'b0);
    check("s2.timeout_count", o_timeout_count, 16'd1);
    beat(1'b1, 1'b0, 16'd2, 32'h0);
    for (int k = 1; k < TIMEOUT; k++) beat(1'b0, 1'b0, 16'd2, 32'h300 + k);
    beat(1'b0, 1'b1, 16'd2, 32'hE0);
    check("s2.marker256_ovld", o_tvalid, 1'b1);
    beat(1'b0, 1'b0, 16'd2, 32'hE1);
    check("s2.marker256_tlast", o_tvalid & o_tlast, 1'b1);
    idle();
    check("s2.burst_count", o_burst_count, 16'd1);
    check("s2.timeout_kept", o_timeout_count, 16'd1);

    // burst_len=3 with o_tready toggling every cycle.
    do_reset();
    beat(1'b1, 1'b0, 16'd3, 32'h0);
    bp_data[0] = 32'hF00D0000; bp_data[1] = 32'hF00D0001; bp_data[2] = 32'hF00D0002;
    idx = 0; got = 0; cyc = 0;
    while (got < 3 && cyc < 20) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, (idx == 0), cyc[0], 16'd3, bp_data[idx], 1'b0);
      check($sformatf("s3.i_tready_c%0d", cyc), i_tready, cyc[0]);
      if (o_tvalid && o_tready) begin
        bp_got_d[got] = o_tdata;
        bp_got_l[got] = o_tlast;
        got++;
      end
      if (i_tvalid && i_tready) idx++;
      cyc++;
    end
    check("s3.beats", got, 3);
    for (int k = 0; k < got; k++) begin
      check($sformatf("s3.data%0d", k), bp_got_d[k], bp_data[k]);
      check($sformatf("s3.tlast%0d", k), bp_got_l[k], (k == 2));
    end
    beat(1'b0, 1'b0, 16'd3, 32'h0);
    check("s3.after_ovld", o_tvalid, 1'b0);

    // enable dropped mid-burst: burst still completes and counts.
    do_reset();
    beat(1'b1, 1'b0, 16'd3, 32'h0);
    beat(1'b0, 1'b1, 16'd3, 32'h40);
    check("s4.marker_ovld", o_tvalid, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 32'h41, 1'b0);
    check("s4.mid_ovld", o_tvalid & ~o_tlast, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 32'h42, 1'b0);
    check("s4.end_tlast", o_tvalid & o_tlast, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 32'h0, 1'b0);
    check("s4.burst_count", o_burst_count, 16'd1);
    idle();
    check("s4.idle_busy", o_busy, 1'b0);

    // Reset on the 2nd beat of a 4-beat burst, then a marker with no prior sync.
    beat(1'b1, 1'b0, 16'd4, 32'h0);
    beat(1'b0, 1'b1, 16'd4, 32'h50);
    check("s5.marker_ovld", o_tvalid, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd4, 32'h51, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd4, 32'h52, 1'b0);
    check("s5.rst_ovld", o_tvalid, 1'b0);
    check("s5.rst_irdy", i_tready, 1'b1);
    check("s5.rst_busy", o_busy, 1'b0);
    check("s5.rst_bc", o_burst_count, 16'd0);
    check("s5.rst_tc", o_timeout_count, 16'd0);
    beat(1'b0, 1'b1, 16'd4, 32'h53);
    check("s5.nosync_ovld", o_tvalid, 1'b0);
    idle();
    check("s5.nosync_busy", o_busy, 1'b0);

    // Saturation and clear priority on the narrow-counter instance (TIMEOUT=2, HOLDOFF=0).
    do_reset();
    for (int k = 0; k < 9; k++) begin
      beat(1'b1, 1'b0, 16'd0, 32'h0);
      beat(1'b0, 1'b1, 16'd0, 32'h60 + k);
      if (k == 0) check("s6.len0_tlast", s_o_tvalid & s_o_tlast, 1'b1);
    end
    idle();
    check("s6.burst_sat", s_burst_count, 3'h7);
    for (int k = 0; k < 9; k++) begin
      beat(1'b1, 1'b0, 16'd0, 32'h0);
      beat(1'b0, 1'b0, 16'd0, 32'h0);
      beat(1'b0, 1'b0, 16'd0, 32'h0);
    end
    idle();
    check("s6.timeout_sat", s_timeout_count, 3'h7);
    beat(1'b1, 1'b0, 16'd0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 32'h70, 1'b1);
    check("s6.clr_beat_tlast", s_o_tlast & s_o_tvalid, 1'b1);
    idle();
    check("s6.clr_burst", s_burst_count, 3'h0);
    check("s6.clr_timeout", s_timeout_count, 3'h0);

    // Random stream with random valid gaps and output backpressure, scored against the model.
    do_reset();
    items.delete();
    got_q.delete();
    for (int i = 0; i < 3000; i++) begin
      it.sync = ($urandom_range(0, 29) == 0);
      it.last = ((i / 600) % 2 == 1) ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 24) == 0);
      it.bl   = LEN_W'($urandom_range(0, 6));
      it.d    = $urandom;
      items.push_back(it);
    end
    run_model();
    idx = 0;
    cyc = 0;
    while (idx < items.size() && cyc < 30000) begin
      vld = ($urandom_range(0, 4) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      drive(1'b0, 1'b1, vld, items[idx].sync, items[idx].last, rdy, items[idx].bl,
            vld ? items[idx].d : WIDTH'($urandom), 1'b0);
      if (o_tvalid && o_tready) got_q.push_back(out_t'{o_tdata, o_tlast});
      if (i_tvalid && i_tready) idx++;
      cyc++;
    end
    check("rand.all_items_accepted", idx, items.size());
    idle();
    check("rand.out_len", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("rand.data%0d", i), got_q[i].d, exp_q[i].d);
      check($sformatf("rand.tlast%0d", i), got_q[i].l, exp_q[i].l);
    end
    check("rand.burst_count", o_burst_count, exp_bc);
    check("rand.timeout_count", o_timeout_count, exp_tc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
